// File: rtl/hit_resolver.sv
// Hit resolution between two fighters: box overlap test, damage and health tracking,
// and the round FSM (wait / fight / hitstop / KO) that drives freeze, hit and winner outputs.
module hit_resolver #(
    parameter int         HP_W       = 7,
    parameter int         HEALTH_MAX = 100,
    parameter int         DAMAGE     = 10,
    parameter int         HITSTOP    = 8,
    parameter logic [3:0] ACTIVE_ST  = 4'd4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_tick,
    input  logic            round_start,
    input  logic [3:0]      p1_state,
    input  logic [3:0]      p2_state,
    input  logic [39:0]     p1_hitbox,
    input  logic [39:0]     p1_hurtbox,
    input  logic [39:0]     p2_hitbox,
    input  logic [39:0]     p2_hurtbox,
    output logic [HP_W-1:0] p1_health,
    output logic [HP_W-1:0] p2_health,
    output logic            p1_hit,
    output logic            p2_hit,
    output logic            freeze,
    output logic            game_over,
    output logic [1:0]      winner
);

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_FIGHT   = 2'd1,
        ST_HITSTOP = 2'd2,
        ST_KO      = 2'd3
    } state_t;

    localparam logic [HP_W-1:0] HEALTH_INIT  = HP_W'(HEALTH_MAX);
    localparam logic [7:0]      HITSTOP_LOAD = 8'(HITSTOP - 1);

    function automatic logic [9:0] min10(input logic [9:0] a, input logic [9:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [9:0] max10(input logic [9:0] a, input logic [9:0] b);
        return (a < b) ? b : a;
    endfunction

    // Boxes are {x1,x2,y1,y2}; corners may arrive in either order (mirrored right-side boxes).
    function automatic logic boxes_overlap(input logic [39:0] a, input logic [39:0] b);
        logic [9:0] a_xlo, a_xhi, a_ylo, a_yhi;
        logic [9:0] b_xlo, b_xhi, b_ylo, b_yhi;
        a_xlo = min10(a[39:30], a[29:20]);
        a_xhi = max10(a[39:30], a[29:20]);
        a_ylo = min10(a[19:10], a[9:0]);
        a_yhi = max10(a[19:10], a[9:0]);
        b_xlo = min10(b[39:30], b[29:20]);
        b_xhi = max10(b[39:30], b[29:20]);
        b_ylo = min10(b[19:10], b[9:0]);
        b_yhi = max10(b[19:10], b[9:0]);
        return (a_xlo <= b_xhi) && (b_xlo <= a_xhi) && (a_ylo <= b_yhi) && (b_ylo <= a_yhi);
    endfunction

    // Compared at 32 bits so a DAMAGE wider than HP_W still saturates correctly.
    function automatic logic [HP_W-1:0] apply_damage(input logic [HP_W-1:0] h);
        logic [31:0] h_wide;
        h_wide = 32'(h);
        if (h_wide > 32'(DAMAGE)) begin
            return HP_W'(h_wide - 32'(DAMAGE));
        end else begin
            return {HP_W{1'b0}};
        end
    endfunction

    state_t          state_r, state_next_s;
    logic [7:0]      cnt_r, cnt_next_s;
    logic            landed1_r, landed1_next_s;
    logic            landed2_r, landed2_next_s;
    logic [HP_W-1:0] p1_health_r, p1_health_next_s;
    logic [HP_W-1:0] p2_health_r, p2_health_next_s;
    logic            p1_hit_r, p1_hit_next_s;
    logic            p2_hit_r, p2_hit_next_s;
    logic            freeze_r, game_over_r;
    logic [1:0]      winner_r, winner_next_s;

    logic            p1_active_s, p2_active_s;
    logic            hit1_s, hit2_s;
    logic [HP_W-1:0] p1_after_s, p2_after_s;
    logic            p1_dead_s, p2_dead_s;

    assign p1_active_s = (p1_state == ACTIVE_ST);
    assign p2_active_s = (p2_state == ACTIVE_ST);

    // hit1: player 1 strikes player 2; hit2: player 2 strikes player 1.
    assign hit1_s = frame_tick && (state_r == ST_FIGHT) && p1_active_s && !landed1_r
                    && boxes_overlap(p1_hitbox, p2_hurtbox);
    assign hit2_s = frame_tick && (state_r == ST_FIGHT) && p2_active_s && !landed2_r
                    && boxes_overlap(p2_hitbox, p1_hurtbox);

    assign p2_after_s = hit1_s ? apply_damage(p2_health_r) : p2_health_r;
    assign p1_after_s = hit2_s ? apply_damage(p1_health_r) : p1_health_r;
    assign p1_dead_s  = (p1_after_s == {HP_W{1'b0}});
    assign p2_dead_s  = (p2_after_s == {HP_W{1'b0}});

    // Next-state and next-output logic for the round FSM.
    always_comb begin
        state_next_s     = state_r;
        cnt_next_s       = cnt_r;
        landed1_next_s   = landed1_r;
        landed2_next_s   = landed2_r;
        p1_health_next_s = p1_health_r;
        p2_health_next_s = p2_health_r;
        p1_hit_next_s    = 1'b0;
        p2_hit_next_s    = 1'b0;
        winner_next_s    = winner_r;

        if (round_start) begin
            state_next_s     = ST_FIGHT;
            cnt_next_s       = 8'd0;
            landed1_next_s   = 1'b0;
            landed2_next_s   = 1'b0;
            p1_health_next_s = HEALTH_INIT;
            p2_health_next_s = HEALTH_INIT;
            winner_next_s    = 2'b00;
        end else if (frame_tick) begin
            case (state_r)
                ST_FIGHT: begin
                    landed1_next_s   = hit1_s || (p1_active_s && landed1_r);
                    landed2_next_s   = hit2_s || (p2_active_s && landed2_r);
                    p1_health_next_s = p1_after_s;
                    p2_health_next_s = p2_after_s;
                    p1_hit_next_s    = hit2_s;
                    p2_hit_next_s    = hit1_s;
                    if ((hit1_s || hit2_s) && (p1_dead_s || p2_dead_s)) begin
                        state_next_s  = ST_KO;
                        winner_next_s = {p1_dead_s, p2_dead_s};
                    end else if (hit1_s || hit2_s) begin
                        state_next_s = ST_HITSTOP;
                        cnt_next_s   = HITSTOP_LOAD;
                    end else begin
                        state_next_s = ST_FIGHT;
                    end
                end
                ST_HITSTOP: begin
                    landed1_next_s = p1_active_s && landed1_r;
                    landed2_next_s = p2_active_s && landed2_r;
                    if (cnt_r == 8'd0) begin
                        state_next_s = ST_FIGHT;
                    end else begin
                        cnt_next_s = cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_next_s = state_r;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // State, health, latches and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_WAIT;
            cnt_r       <= 8'd0;
            landed1_r   <= 1'b0;
            landed2_r   <= 1'b0;
            p1_health_r <= HEALTH_INIT;
            p2_health_r <= HEALTH_INIT;
            p1_hit_r    <= 1'b0;
            p2_hit_r    <= 1'b0;
            freeze_r    <= 1'b0;
            game_over_r <= 1'b0;
            winner_r    <= 2'b00;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            landed1_r   <= landed1_next_s;
            landed2_r   <= landed2_next_s;
            p1_health_r <= p1_health_next_s;
            p2_health_r <= p2_health_next_s;
            p1_hit_r    <= p1_hit_next_s;
            p2_hit_r    <= p2_hit_next_s;
            freeze_r    <= (state_next_s == ST_HITSTOP);
            game_over_r <= (state_next_s == ST_KO);
            winner_r    <= winner_next_s;
        end
    end

    assign p1_health = p1_health_r;
    assign p2_health = p2_health_r;
    assign p1_hit    = p1_hit_r;
    assign p2_hit    = p2_hit_r;
    assign freeze    = freeze_r;
    assign game_over = game_over_r;
    assign winner    = winner_r;

endmodule

// File: tb/tb_hit_resolver.sv
// Directed bench for hit_resolver: overlap edges, one-hit-per-attack, hitstop length,
// trades, lethal saturation/winner codes, round restart and async reset.
module tb_hit_resolver;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic        round_start;
    logic [3:0]  p1_state, p2_state;
    logic [39:0] p1_hitbox, p1_hurtbox, p2_hitbox, p2_hurtbox;
    logic [6:0]  p1_health, p2_health;
    logic        p1_hit, p2_hit, freeze, game_over;
    logic [1:0]  winner;

    int tests_run    = 0;
    int tests_failed = 0;

    hit_resolver dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .round_start(round_start),
        .p1_state   (p1_state),
        .p2_state   (p2_state),
        .p1_hitbox  (p1_hitbox),
        .p1_hurtbox (p1_hurtbox),
        .p2_hitbox  (p2_hitbox),
        .p2_hurtbox (p2_hurtbox),
        .p1_health  (p1_health),
        .p2_health  (p2_health),
        .p1_hit     (p1_hit),
        .p2_hit     (p2_hit),
        .freeze     (freeze),
        .game_over  (game_over),
        .winner     (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [39:0] box(input logic [9:0] x1, input logic [9:0] x2,
                                        input logic [9:0] y1, input logic [9:0] y2);
        return {x1, x2, y1, y2};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic start_round();
        @(negedge clk);
        round_start = 1'b1;
        @(negedge clk);
        round_start = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b0;
        frame_tick  = 1'b0;
        round_start = 1'b0;
        p1_state    = 4'd0;
        p2_state    = 4'd0;
        p1_hitbox   = box(10'd240, 10'd323, 10'd194, 10'd227);
        p1_hurtbox  = box(10'd100, 10'd150, 10'd170, 10'd320);
        p2_hitbox   = box(10'd600, 10'd650, 10'd200, 10'd220);
        p2_hurtbox  = box(10'd300, 10'd250, 10'd170, 10'd320);
        repeat (3) idle();

        check("reset_p1_health", 32'(p1_health), 32'd100);
        check("reset_p2_health", 32'(p2_health), 32'd100);
        check("reset_freeze", 32'(freeze), 32'd0);
        check("reset_game_over", 32'(game_over), 32'd0);
        check("reset_winner", 32'(winner), 32'd0);
        rst = 1'b1;

        // WAIT ignores frame_tick even with an overlapping active attack
        p1_state = 4'd4;
        tick();
        check("wait_no_hit", 32'(p2_health), 32'd100);

        // Test 1: no overlap, and a one-pixel gap on x
        p2_hurtbox = box(10'd501, 10'd448, 10'd170, 10'd320);
        start_round();
        tick();
        check("t1_no_overlap", 32'(p2_health), 32'd100);
        check("t1_no_pulse", 32'(p2_hit), 32'd0);
        p2_hurtbox = box(10'd400, 10'd324, 10'd170, 10'd320);
        tick();
        check("t1_gap_by_one", 32'(p2_health), 32'd100);

        // Test 2: landed hit, pulse, exactly 8 frozen frame_ticks
        p2_hurtbox = box(10'd300, 10'd250, 10'd170, 10'd320);
        tick();
        check("t2_p2_health", 32'(p2_health), 32'd90);
        check("t2_p1_health", 32'(p1_health), 32'd100);
        check("t2_p2_hit", 32'(p2_hit), 32'd1);
        check("t2_p1_hit", 32'(p1_hit), 32'd0);
        check("t2_freeze_on", 32'(freeze), 32'd1);
        idle();
        check("t2_pulse_one_cycle", 32'(p2_hit), 32'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("t2_freeze_hold", 32'(freeze), 32'd1);
        end
        tick();
        check("t2_freeze_off", 32'(freeze), 32'd0);

        // Test 3: held active state does not re-hit; leave and re-enter does
        repeat (11) tick();
        check("t3_single_hit", 32'(p2_health), 32'd90);
        check("t3_no_freeze", 32'(freeze), 32'd0);
        p1_state = 4'd0;
        tick();
        p1_state = 4'd4;
        tick();
        check("t3_second_hit", 32'(p2_health), 32'd80);
        check("t3_second_freeze", 32'(freeze), 32'd1);
        repeat (8) tick();
        check("t3_back_to_fight", 32'(freeze), 32'd0);

        // Test 4: trade; p2 hitbox touches p1 hurtbox exactly at x=260
        p1_hurtbox = box(10'd320, 10'd260, 10'd150, 10'd300);
        p2_hitbox  = box(10'd200, 10'd260, 10'd180, 10'd210);
        start_round();
        check("t4_reload_p2", 32'(p2_health), 32'd100);
        p2_state = 4'd4;
        tick();
        check("t4_p1_health", 32'(p1_health), 32'd90);
        check("t4_p2_health", 32'(p2_health), 32'd90);
        check("t4_p1_hit", 32'(p1_hit), 32'd1);
        check("t4_p2_hit", 32'(p2_hit), 32'd1);
        repeat (8) tick();

        // Test 5a: p1 whittles p2 down to 0 -> KO, winner 01
        p2_state = 4'd0;
        start_round();
        for (int i = 1; i <= 10; i++) begin
            p1_state = 4'd4;
            tick();
            check("t5_p2_health_step", 32'(p2_health), 32'(100 - 10 * i));
            if (i < 10) begin
                repeat (8) tick();
                p1_state = 4'd0;
                tick();
            end
        end
        check("t5_game_over", 32'(game_over), 32'd1);
        check("t5_winner_p1", 32'(winner), 32'd1);
        check("t5_no_freeze_ko", 32'(freeze), 32'd0);
        check("t5_p1_health", 32'(p1_health), 32'd100);
        p1_state = 4'd0;
        tick();
        p1_state = 4'd4;
        tick();
        check("t5_ko_ignores_tick", 32'(p2_health), 32'd0);
        check("t5_ko_held", 32'(game_over), 32'd1);
        check("t5_winner_held", 32'(winner), 32'd1);

        // Test 5b: lethal trade -> winner 11
        start_round();
        check("t6_ko_restart_go", 32'(game_over), 32'd0);
        check("t6_ko_restart_win", 32'(winner), 32'd0);
        check("t6_ko_restart_hp", 32'(p2_health), 32'd100);
        for (int i = 1; i <= 10; i++) begin
            p1_state = 4'd4;
            p2_state = 4'd4;
            tick();
            if (i < 10) begin
                repeat (8) tick();
                p1_state = 4'd0;
                p2_state = 4'd0;
                tick();
            end
        end
        check("t5_trade_p1_zero", 32'(p1_health), 32'd0);
        check("t5_trade_p2_zero", 32'(p2_health), 32'd0);
        check("t5_winner_draw", 32'(winner), 32'd3);
        check("t5_trade_go", 32'(game_over), 32'd1);

        // Test 6: round_start during HITSTOP, and round_start beating frame_tick
        start_round();
        tick();
        check("t6_trade_freeze", 32'(freeze), 32'd1);
        start_round();
        check("t6_hs_restart_freeze", 32'(freeze), 32'd0);
        check("t6_hs_restart_p1", 32'(p1_health), 32'd100);
        check("t6_hs_restart_p2", 32'(p2_health), 32'd100);
        @(negedge clk);
        round_start = 1'b1;
        frame_tick  = 1'b1;
        @(negedge clk);
        round_start = 1'b0;
        frame_tick  = 1'b0;
        check("t6_start_priority", 32'(p2_health), 32'd100);
        check("t6_start_no_pulse", 32'(p2_hit), 32'd0);
        tick();
        check("t6_fight_after", 32'(p2_health), 32'd90);

        // Async reset mid-hitstop takes effect without a clock edge
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_p1", 32'(p1_health), 32'd100);
        check("t6_async_p2", 32'(p2_health), 32'd100);
        check("t6_async_freeze", 32'(freeze), 32'd0);
        idle();
        rst = 1'b1;
        tick();
        check("t6_after_reset_wait", 32'(p2_health), 32'd100);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
